// File: rtl/hole_pkg.sv
// Shared types and constants for the hole / pocket detection logic.
package hole_pkg;

    typedef logic [2:0] hole_id_t;

    localparam hole_id_t HOLE_NONE = 3'd0;
    localparam int       NUM_HOLES = 6;

    typedef enum logic [1:0] {
        ACCUM,
        SCAN,
        EMIT
    } pocket_state_t;

    // Only ids 1..NUM_HOLES name a real hole; 0 and 7 are treated as noise.
    function automatic logic is_real_hole(input hole_id_t h);
        return (h != HOLE_NONE) && (h <= hole_id_t'(NUM_HOLES));
    endfunction

endpackage

// File: rtl/ball_overlap_counter.sv
// Per-ball overlap counter: counts ball/hole overlap pixels within one frame
// (saturating) and remembers which hole the first overlapping pixel belonged to.
module ball_overlap_counter
    import hole_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             hit,
    input  hole_id_t         hole_in,
    output logic [CNT_W-1:0] cnt,
    output hole_id_t         hole
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // A frame clear restarts the count, but a hit on that same cycle already
    // belongs to the new frame, so it becomes the first pixel of it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            hole <= HOLE_NONE;
        end else if (clear) begin
            if (hit) begin
                cnt  <= CNT_W'(1);
                hole <= hole_in;
            end else begin
                cnt  <= '0;
                hole <= HOLE_NONE;
            end
        end else if (hit) begin
            if (cnt == '0) begin
                hole <= hole_in;
            end
            if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/hole_pocket_detector.sv
// Pocket detector: accumulates per-ball overlap with hole hit regions, snapshots
// the counts at each frame boundary, then scans the snapshot and hands one
// pocket event per newly pocketed ball to the game logic over valid/ready.
module hole_pocket_detector
    import hole_pkg::*;
#(
    parameter  int NUM_BALLS   = 16,
    parameter  int MIN_OVERLAP = 8,
    parameter  int CNT_W       = 6,
    localparam int IDX_W       = $clog2(NUM_BALLS)
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic                 Hit_Hole_DR,
    input  logic [2:0]           Hole_ID,
    input  logic [NUM_BALLS-1:0] Ball_DR,
    input  logic                 ball_restore,
    input  logic                 pocket_ready,
    output logic                 pocket_valid,
    output logic [IDX_W-1:0]     pocket_ball_id,
    output logic [2:0]           pocket_hole_id,
    output logic [NUM_BALLS-1:0] pocketed_mask,
    output logic                 cue_foul,
    output logic                 frame_overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BALLS - 1);

    logic [NUM_BALLS-1:0] ball_hit;
    logic [CNT_W-1:0]     cnt [NUM_BALLS];
    hole_id_t             hole [NUM_BALLS];
    logic                 hole_ok;

    logic [NUM_BALLS-1:0] snap_hit;
    hole_id_t             snap_hole [NUM_BALLS];

    pocket_state_t        state;
    pocket_state_t        next_state;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     next_idx;
    logic                 cur_hit;
    logic                 accept;
    logic                 advance;

    assign hole_ok = is_real_hole(Hole_ID);

    for (genvar i = 0; i < NUM_BALLS; i++) begin : g_ball
        assign ball_hit[i] = Hit_Hole_DR && Ball_DR[i] && hole_ok && !pocketed_mask[i];

        ball_overlap_counter #(
            .CNT_W(CNT_W)
        ) u_counter (
            .clk    (clk),
            .reset  (resetN),
            .clear  (startOfFrame),
            .hit    (ball_hit[i]),
            .hole_in(Hole_ID),
            .cnt    (cnt[i]),
            .hole   (hole[i])
        );
    end

    // Freeze last frame's verdicts; a boundary arriving mid-scan is dropped
    // so the scan in progress keeps a consistent view.
    always_ff @(posedge clk) begin
        if (resetN) begin
            snap_hit <= '0;
            for (int i = 0; i < NUM_BALLS; i++) begin
                snap_hole[i] <= HOLE_NONE;
            end
        end else if (state == ACCUM && startOfFrame) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                snap_hit[i]  <= (cnt[i] >= CNT_W'(MIN_OVERLAP)) && !pocketed_mask[i];
                snap_hole[i] <= hole[i];
            end
        end
    end

    assign cur_hit        = snap_hit[idx] && !pocketed_mask[idx];
    assign pocket_ball_id = idx;
    assign pocket_hole_id = snap_hole[idx];

    // Scan state register and ball index.
    always_ff @(posedge clk) begin
        if (resetN) begin
            state <= ACCUM;
            idx   <= '0;
        end else begin
            state <= next_state;
            idx   <= next_idx;
        end
    end

    // Scan/emit decisions; a hit is offered in the SCAN cycle itself and held
    // in EMIT until accepted. Valid depends only on registered state.
    always_comb begin
        next_state   = state;
        next_idx     = idx;
        pocket_valid = 1'b0;
        accept       = 1'b0;
        advance      = 1'b0;
        case (state)
            ACCUM: begin
                if (startOfFrame) begin
                    next_state = SCAN;
                    next_idx   = '0;
                end
            end
            SCAN: begin
                if (cur_hit) begin
                    pocket_valid = 1'b1;
                    if (pocket_ready) begin
                        accept  = 1'b1;
                        advance = 1'b1;
                    end else begin
                        next_state = EMIT;
                    end
                end else begin
                    advance = 1'b1;
                end
            end
            EMIT: begin
                pocket_valid = 1'b1;
                if (pocket_ready) begin
                    accept  = 1'b1;
                    advance = 1'b1;
                end
            end
            default: begin
                next_state = ACCUM;
                next_idx   = '0;
            end
        endcase
        if (advance) begin
            if (idx == LAST_IDX) begin
                next_state = ACCUM;
                next_idx   = '0;
            end else begin
                next_state = SCAN;
                next_idx   = idx + IDX_W'(1);
            end
        end
    end

    // Pocketed mask, cue-ball foul pulse and sticky overrun flag; a restore
    // beats a simultaneous accept so a new rack starts fully clear.
    always_ff @(posedge clk) begin
        if (resetN) begin
            pocketed_mask <= '0;
            cue_foul      <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            cue_foul <= accept && (idx == '0);
            if (ball_restore) begin
                pocketed_mask <= '0;
            end else if (accept) begin
                pocketed_mask[idx] <= 1'b1;
            end
            if (startOfFrame && state != ACCUM) begin
                frame_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hole_pocket_detector.sv
// Self-checking bench for hole_pocket_detector: directed scenarios with
// randomized filler pixels, then random frames, against a frame-level model.
module tb_hole_pocket_detector;

    localparam int NB = 16;

    logic          clk = 1'b0;
    logic          resetN = 1'b1;
    logic          startOfFrame = 1'b0;
    logic          Hit_Hole_DR = 1'b0;
    logic [2:0]    Hole_ID = 3'd0;
    logic [NB-1:0] Ball_DR = '0;
    logic          ball_restore = 1'b0;
    logic          pocket_ready = 1'b0;
    logic          pocket_valid;
    logic [3:0]    pocket_ball_id;
    logic [2:0]    pocket_hole_id;
    logic [NB-1:0] pocketed_mask;
    logic          cue_foul;
    logic          frame_overrun;

    int assertions = 0;
    int failures = 0;

    typedef struct {
        int ball;
        int hole;
    } ev_t;

    ev_t           q[$];
    int            mcnt [NB];
    int            mhole [NB];
    logic [NB-1:0] mmask = '0;

    hole_pocket_detector dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .Hit_Hole_DR   (Hit_Hole_DR),
        .Hole_ID       (Hole_ID),
        .Ball_DR       (Ball_DR),
        .ball_restore  (ball_restore),
        .pocket_ready  (pocket_ready),
        .pocket_valid  (pocket_valid),
        .pocket_ball_id(pocket_ball_id),
        .pocket_hole_id(pocket_hole_id),
        .pocketed_mask (pocketed_mask),
        .cue_foul      (cue_foul),
        .frame_overrun (frame_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertions++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model_counts();
        for (int i = 0; i < NB; i++) begin
            mcnt[i]  = 0;
            mhole[i] = 0;
        end
    endtask

    // One pixel; the model applies the counting rule at frame level.
    task automatic pixel(input logic hh, input logic [2:0] hid, input logic [NB-1:0] bdr);
        Hit_Hole_DR = hh;
        Hole_ID     = hid;
        Ball_DR     = bdr;
        @(posedge clk);
        #1;
        for (int i = 0; i < NB; i++) begin
            if (hh && bdr[i] && hid >= 1 && hid <= 6 && !mmask[i]) begin
                if (mcnt[i] == 0) mhole[i] = hid;
                if (mcnt[i] < 63) mcnt[i]++;
            end
        end
        Hit_Hole_DR = 1'b0;
        Hole_ID     = 3'd0;
        Ball_DR     = '0;
    endtask

    // Pixels that must never count: no hit region, or hole id 0/7.
    task automatic noise(input int n);
        logic [2:0] bad;
        for (int k = 0; k < n; k++) begin
            bad = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd7;
            if ($urandom_range(0, 1) == 0) pixel(1'b0, 3'($urandom_range(0, 7)), NB'($urandom));
            else pixel(1'b1, bad, NB'($urandom));
        end
    endtask

    task automatic overlap(input int ball, input int hole, input int npx);
        logic [NB-1:0] one;
        one = NB'(1);
        for (int k = 0; k < npx; k++) begin
            pixel(1'b1, 3'(hole), one << ball);
            noise($urandom_range(0, 2));
        end
    endtask

    task automatic random_pixels(input int n);
        logic [NB-1:0] one;
        one = NB'(1);
        for (int k = 0; k < n; k++) begin
            pixel(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), one << $urandom_range(0, NB - 1));
        end
    endtask

    // Frame boundary while idle: the model lists the expected events in order.
    task automatic frame_boundary();
        startOfFrame = 1'b1;
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        q.delete();
        for (int i = 0; i < NB; i++) begin
            if (mcnt[i] >= 8 && !mmask[i]) q.push_back('{i, mhole[i]});
        end
        clear_model_counts();
    endtask

    task automatic restore();
        ball_restore = 1'b1;
        @(posedge clk);
        #1;
        ball_restore = 1'b0;
        mmask = '0;
    endtask

    task automatic do_reset();
        resetN = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b0;
        mmask = '0;
        q.delete();
        clear_model_counts();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, pocket_valid, 0);
        check({tag, "_ball"}, pocket_ball_id, 0);
        check({tag, "_hole"}, pocket_hole_id, 0);
        check({tag, "_mask"}, pocketed_mask, 0);
        check({tag, "_foul"}, cue_foul, 0);
        check({tag, "_overrun"}, frame_overrun, 0);
    endtask

    // Drives ready and checks every offered event against the expected queue.
    task automatic serve_events(input int hold, input bit rand_ready, input bit check_latency,
                                input bit restore_on_first);
        bit first = 1'b1;
        bit restored = 1'b0;
        bit expect_foul = 1'b0;
        bit done = 1'b0;
        int tail = 0;
        for (int n = 0; n < 600 && !done; n++) begin
            ball_restore = 1'b0;
            pocket_ready = 1'b0;
            check("cue_foul", cue_foul, expect_foul);
            expect_foul = 1'b0;
            if (pocket_valid) begin
                if (q.size() == 0) begin
                    check("spurious_valid", pocket_valid, 0);
                end else begin
                    check("ball_id", pocket_ball_id, q[0].ball);
                    check("hole_id", pocket_hole_id, q[0].hole);
                    if (first && check_latency) check("first_latency", n, q[0].ball);
                    first = 1'b0;
                    pocket_ready = rand_ready ? 1'($urandom_range(0, 1)) : (n >= hold);
                    if (pocket_ready) begin
                        expect_foul = (q[0].ball == 0);
                        if (restore_on_first && !restored) begin
                            ball_restore = 1'b1;
                            restored = 1'b1;
                            mmask = '0;
                        end else begin
                            mmask[q[0].ball] = 1'b1;
                        end
                        void'(q.pop_front());
                    end
                end
            end
            if (q.size() == 0) tail++;
            if (tail > NB + 2) done = 1'b1;
            @(posedge clk);
            #1;
        end
        pocket_ready = 1'b0;
        ball_restore = 1'b0;
        check("events_drained", q.size(), 0);
        check("pocketed_mask", pocketed_mask, mmask);
    endtask

    initial begin
        clear_model_counts();

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        resetN = 1'b0;
        check_idle_outputs("reset");

        // Ball 3 over hole 2 for 10 px: one event, then never again.
        noise(4);
        overlap(3, 2, 10);
        frame_boundary();
        serve_events(0, 1'b0, 1'b1, 1'b0);
        check("mask_ball3", pocketed_mask[3], 1);
        overlap(3, 2, 10);
        frame_boundary();
        serve_events(0, 1'b0, 1'b1, 1'b0);

        // 7 px is below threshold; the leftover must not carry into the next frame.
        overlap(4, 5, 7);
        frame_boundary();
        serve_events(0, 1'b0, 1'b1, 1'b0);
        overlap(4, 5, 1);
        frame_boundary();
        serve_events(0, 1'b0, 1'b1, 1'b0);

        // Balls 1 and 5 together, consumer stalls ~20 cycles.
        overlap(1, 3, 9);
        overlap(5, 6, 12);
        frame_boundary();
        serve_events(21, 1'b0, 1'b1, 1'b0);

        // Cue ball into hole 6.
        overlap(0, 6, 9);
        frame_boundary();
        serve_events(0, 1'b0, 1'b1, 1'b0);
        check("mask_ball0", pocketed_mask[0], 1);

        // First hole wins; hole 7 pixels ignored; exactly MIN_OVERLAP pixels.
        overlap(2, 4, 3);
        for (int k = 0; k < 5; k++) pixel(1'b1, 3'd7, NB'(4));
        overlap(2, 1, 5);
        frame_boundary();
        serve_events(0, 1'b0, 1'b1, 1'b0);

        // Boundary during EMIT: overrun set, new snapshot (ball 8) discarded.
        overlap(6, 3, 8);
        frame_boundary();
        for (int k = 0; k < 9; k++) pixel(1'b1, 3'd5, NB'(256));
        check("emit_waiting", pocket_valid, 1);
        startOfFrame = 1'b1;
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        clear_model_counts();
        check("overrun_set", frame_overrun, 1);
        serve_events(0, 1'b0, 1'b0, 1'b0);
        frame_boundary();
        serve_events(0, 1'b0, 1'b1, 1'b0);
        check("overrun_sticky", frame_overrun, 1);

        // Restore clears the mask.
        restore();
        check("restore_mask", pocketed_mask, 0);

        // Restore on the same cycle as the cue-ball accept: foul pulses, bit stays 0.
        overlap(0, 3, 9);
        overlap(9, 5, 9);
        frame_boundary();
        serve_events(0, 1'b0, 1'b1, 1'b1);

        // Random frames with random consumer back-pressure.
        for (int f = 0; f < 6; f++) begin
            if ($urandom_range(0, 1) == 1) restore();
            for (int b = 0; b < $urandom_range(1, 4); b++) begin
                overlap($urandom_range(0, NB - 1), $urandom_range(1, 6),
                        ($urandom_range(0, 5) == 0) ? 70 : $urandom_range(4, 14));
            end
            random_pixels(12);
            frame_boundary();
            serve_events(0, 1'b1, 1'b1, 1'b0);
        end

        // Reset while an event is pending drops it.
        restore();
        overlap(10, 2, 9);
        frame_boundary();
        repeat (12) @(posedge clk);
        #1;
        check("pending_before_reset", pocket_valid, 1);
        resetN = 1'b1;
        @(posedge clk);
        #1;
        resetN = 1'b0;
        mmask = '0;
        q.delete();
        clear_model_counts();
        check_idle_outputs("mid_emit_reset");
        frame_boundary();
        serve_events(0, 1'b0, 1'b1, 1'b0);

        do_reset();
        check_idle_outputs("final_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
